// File: rtl/cp0_exc_seq.sv
// cp0_exc_seq
// Exception / ERET sequencer that sits in front of the CP0 register file and
// owns its single read/write port. A trap request reads Status, decides
// whether the trap is enabled, then writes Status, Cause and EPC on
// successive cycles and returns the handler address. ERET restores Status
// and returns EPC. While idle, mfc0/mtc0 accesses from the control unit
// pass straight through to CP0.

module cp0_exc_seq #(
   parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
   parameter logic [4:0]  ADDR_STATUS  = 5'd12,
   parameter logic [4:0]  ADDR_CAUSE   = 5'd13,
   parameter logic [4:0]  ADDR_EPC     = 5'd14
) (
   input  logic        clk,
   input  logic        rst,

   // Trap / ERET requests from the control unit
   input  logic        exc_req,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        eret_req,

   // mfc0 / mtc0 accesses from the control unit
   input  logic        sw_r,
   input  logic        sw_w,
   input  logic [4:0]  sw_raddr,
   input  logic [4:0]  sw_waddr,
   input  logic [31:0] sw_wdata,
   output logic [31:0] sw_rdata,

   // CP0 register file port
   input  logic [31:0] cp0_rdata,
   output logic        cp0_r,
   output logic        cp0_w,
   output logic [4:0]  cp0_raddr,
   output logic [4:0]  cp0_waddr,
   output logic [31:0] cp0_wdata,

   // Sequencer status towards the control unit
   output logic        busy,
   output logic        done,
   output logic        taken,
   output logic [31:0] target_pc
);

   // ExcCodes that have their own enable bit in Status[3:1]
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_BREAK   = 5'd9;
   localparam logic [4:0] EXC_TEQ     = 5'd13;

   // Status keeps a small stack of mode bits; a trap pushes it left by one
   // 5-bit frame, ERET pops it back.
   localparam int unsigned STATUS_FRAME = 5;

   typedef enum logic [3:0] {
      S_IDLE,
      S_EX_RD_ST,
      S_EX_W_ST,
      S_EX_W_CA,
      S_EX_W_EPC,
      S_ER_RD_ST,
      S_ER_W_ST,
      S_ER_RD_EPC,
      S_DONE
   } state_t;

   state_t      state;
   logic [31:0] status_q;   // Status as read at the start of the sequence
   logic [4:0]  code_q;     // ExcCode latched with the request
   logic [31:0] pc_q;       // PC of the trapping instruction

   logic [31:0] status_pushed;
   logic [31:0] status_popped;
   logic [31:0] cause_word;

   // Global enable in Status[0]; syscall/break/teq each have their own mask
   // bit, any other code is governed by the global enable alone.
   function automatic logic trap_enabled(input logic [3:0] st,
                                         input logic [4:0] code);
      logic mask_bit;
      case (code)
         EXC_SYSCALL: mask_bit = st[1];
         EXC_BREAK:   mask_bit = st[2];
         EXC_TEQ:     mask_bit = st[3];
         default:     mask_bit = 1'b1;
      endcase
      return st[0] & mask_bit;
   endfunction

   // Write data words derived from the captured registers only, so the
   // CP0 write port is stable from the posedge of each write state.
   assign status_pushed = status_q << STATUS_FRAME;
   assign status_popped = status_q >> STATUS_FRAME;
   assign cause_word    = {25'b0, code_q, 2'b00};

   // Sequencer state, captured operands and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         status_q  <= '0;
         code_q    <= '0;
         pc_q      <= '0;
         target_pc <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         taken     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout: every register here
         // must see the pre-edge value of the others, whatever the order.
         case (state)
            S_IDLE: begin
               if (exc_req) begin
                  code_q <= exc_code;
                  pc_q   <= exc_pc;
                  busy   <= 1'b1;
                  state  <= S_EX_RD_ST;
               end else if (eret_req) begin
                  busy  <= 1'b1;
                  state <= S_ER_RD_ST;
               end
            end

            S_EX_RD_ST: begin
               // The enable decision uses the word being read this cycle;
               // status_q only becomes valid after this edge.
               status_q <= cp0_rdata;
               if (trap_enabled(cp0_rdata[3:0], code_q)) begin
                  state <= S_EX_W_ST;
               end else begin
                  done  <= 1'b1;
                  taken <= 1'b0;
                  state <= S_DONE;
               end
            end

            S_EX_W_ST: state <= S_EX_W_CA;

            S_EX_W_CA: state <= S_EX_W_EPC;

            S_EX_W_EPC: begin
               target_pc <= HANDLER_ADDR;
               done      <= 1'b1;
               taken     <= 1'b1;
               state     <= S_DONE;
            end

            S_ER_RD_ST: begin
               status_q <= cp0_rdata;
               state    <= S_ER_W_ST;
            end

            S_ER_W_ST: state <= S_ER_RD_EPC;

            S_ER_RD_EPC: begin
               target_pc <= cp0_rdata;
               done      <= 1'b1;
               taken     <= 1'b1;
               state     <= S_DONE;
            end

            S_DONE: begin
               // Requests still held high are picked up again from IDLE.
               done  <= 1'b0;
               taken <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               done  <= 1'b0;
               taken <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // CP0 port: pass-through of the control unit while idle, otherwise a
   // pure decode of the state register (sw_* ignored while busy).
   always_comb begin
      // NOTE: every output gets a default first so no branch can leave one
      // unassigned and infer a latch.
      cp0_r     = 1'b0;
      cp0_w     = 1'b0;
      cp0_raddr = '0;
      cp0_waddr = '0;
      cp0_wdata = '0;
      case (state)
         S_IDLE: begin
            cp0_r     = sw_r;
            cp0_w     = sw_w;
            cp0_raddr = sw_raddr;
            cp0_waddr = sw_waddr;
            cp0_wdata = sw_wdata;
         end
         S_EX_RD_ST, S_ER_RD_ST: begin
            cp0_r     = 1'b1;
            cp0_raddr = ADDR_STATUS;
         end
         S_EX_W_ST: begin
            cp0_w     = 1'b1;
            cp0_waddr = ADDR_STATUS;
            cp0_wdata = status_pushed;
         end
         S_EX_W_CA: begin
            cp0_w     = 1'b1;
            cp0_waddr = ADDR_CAUSE;
            cp0_wdata = cause_word;
         end
         S_EX_W_EPC: begin
            cp0_w     = 1'b1;
            cp0_waddr = ADDR_EPC;
            cp0_wdata = pc_q;
         end
         S_ER_W_ST: begin
            cp0_w     = 1'b1;
            cp0_waddr = ADDR_STATUS;
            cp0_wdata = status_popped;
         end
         S_ER_RD_EPC: begin
            cp0_r     = 1'b1;
            cp0_raddr = ADDR_EPC;
         end
         default: begin
         end
      endcase
   end

   // mfc0 data path is a plain wire from CP0.
   assign sw_rdata = cp0_rdata;

endmodule

// File: doc/cp0_exc_seq.md
# cp0_exc_seq

Exception/ERET sequencer for the multi-cycle MIPS core, sitting directly upstream of the CP0 register file and owning its read/write port. On a trap request (syscall/break/teq) it reads Status, checks enables, then writes Status, Cause and EPC in successive cycles and returns the handler address. On ERET it restores Status and returns EPC. While idle it passes the control unit's mfc0/mtc0 accesses straight through to CP0.

## Interface
- HANDLER_ADDR, 32'h00400004, PC returned for a taken exception
- ADDR_STATUS, 5'd12, CP0 Status address
- ADDR_CAUSE, 5'd13, CP0 Cause address
- ADDR_EPC, 5'd14, CP0 EPC address

- clk  in  1  clock; single clock, all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- exc_req  in  1  trap request level, sampled only in IDLE
- exc_code  in  5  ExcCode (8 syscall, 9 break, 13 teq)
- exc_pc  in  32  PC of the trapping instruction
- eret_req  in  1  ERET request, sampled only in IDLE
- sw_r / sw_w  in  1 each  mfc0 / mtc0 strobes from the control unit
- sw_raddr / sw_waddr  in  5 each  mfc0 / mtc0 CP0 register number
- sw_wdata  in  32  mtc0 data
- cp0_rdata  in  32  CP0 read data (combinational in CP0)
- cp0_r, cp0_w  out  1 each  CP0 read/write enables
- cp0_raddr, cp0_waddr  out  5 each  CP0 addresses
- cp0_wdata  out  32  CP0 write data
- sw_rdata  out  32  cp0_rdata forwarded to the datapath
- busy  out  1  high in every non-IDLE state; control unit stalls
- done  out  1  one-cycle pulse in DONE
- taken  out  1  valid with done: 1 = redirect PC
- target_pc  out  32  valid with done: new PC

## Operation
- States: IDLE, EX_RD_ST, EX_W_ST, EX_W_CA, EX_W_EPC, ER_RD_ST, ER_W_ST, ER_RD_EPC, DONE.
- IDLE: if exc_req, latch exc_code/exc_pc and go to EX_RD_ST. Else if eret_req, go to ER_RD_ST. exc_req has priority when both are high.
- CP0 port in IDLE: cp0_r/cp0_w/addresses/wdata driven combinationally from sw_*.
- CP0 port in all other states: decoded from the state register only. sw_r and sw_w are ignored.
- EX_RD_ST: cp0_r=1, raddr=ADDR_STATUS. On the exiting edge, capture cp0_rdata into status_q.
  - enable = status_q[0] AND mask bit, where mask bit = Status[1] for code 8, Status[2] for code 9, Status[3] for code 13, and 1 for any other code.
  - enable=1: go to EX_W_ST.
  - enable=0: go to DONE with taken=0.
- EX_W_ST: cp0_w=1, waddr=ADDR_STATUS, wdata = status_q<<5 (32-bit, upper bits discarded, zero-fill).
- EX_W_CA: cp0_w=1, waddr=ADDR_CAUSE, wdata = {25'b0, code_q, 2'b00}.
- EX_W_EPC: cp0_w=1, waddr=ADDR_EPC, wdata = pc_q. Then go to DONE with taken=1, target=HANDLER_ADDR.
- ER_RD_ST: read Status, capture status_q.
- ER_W_ST: write Status = status_q>>5 (logical).
- ER_RD_EPC: cp0_r=1, raddr=ADDR_EPC. Capture cp0_rdata into target register. Then go to DONE with taken=1.
- DONE: done=1, busy=1. Go to IDLE unconditionally. Requests still high are re-sampled in IDLE on the next cycle.
- Outside read states, cp0_r=0. sw_rdata = cp0_rdata at all times.

## Timing
- Reset values:
  - state=IDLE; status_q, code_q, pc_q, target_pc = 0.
  - done=0, taken=0, busy=0.
  - cp0_r, cp0_w, and cp0 addresses/wdata follow sw_* (IDLE decode).
- Request seen at edge E0 (state IDLE). With EX_RD_ST in cycle 1:
  - Taken exception: EX_W_ST cycle 2, EX_W_CA cycle 3, EX_W_EPC cycle 4, done in cycle 5.
  - Masked exception: done in cycle 2.
  - ERET: done in cycle 4.
- Writes: cp0_w is held for the whole state cycle. CP0 commits on the mid-cycle negedge, so wdata and address must be stable from posedge onward (Moore decode, no input paths).
- Reads: cp0_rdata is settled within the read-state cycle and captured at the following posedge.
- busy rises in the cycle after the request edge and falls on the edge leaving DONE.
- Reset mid-sequence: immediate return to IDLE. Partially written CP0 values are irrelevant, because CP0 shares rst.

## Test plan
- Reset then idle; mtc0 Status=0x0000000F via sw_w. Required: cp0_w=1, waddr=12, wdata=0x0F the same cycle; busy=0.
- exc_req, code=8, pc=0x00400100, Status=0x0F. Required:
  - Writes Status=0x1E0, Cause=0x20, EPC=0x00400100 in cycles 2/3/4.
  - done=1 in cycle 5 with taken=1, target_pc=0x00400004.
- Masked break: Status=0x01, exc_req code=9. Required: no cp0_w in any cycle; done in cycle 2 with taken=0; CP0 unchanged.
- eret after the first trap (Status=0x1E0, EPC=0x00400100). Required: writes Status=0x0F in cycle 2; done in cycle 4 with taken=1, target_pc=0x00400100.
- exc_req and eret_req high together with Status=0x0F. Required: exception path taken; eret ignored until IDLE; sw_w pulsed during busy causes no CP0 write.
- rst asserted in EX_W_CA. Required: state returns to IDLE and busy=0 immediately; done is never pulsed; a new exc_req afterward behaves as in scenario 2 timing.
